// File: rtl/nb_rec_pkg.sv
// Shared types and constants for the recurrence engine.
package nb_rec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_NB  = 1'b0;  // simultaneous update
  localparam logic MODE_BLK = 1'b1;  // chained update

  localparam int unsigned K_SUB_DEF = 3;
  localparam int unsigned K_ADD_DEF = 10;

endpackage

// File: rtl/nb_rec_step.sv
// One iteration of a <- b + c, d <- a - K_SUB, b <- d + K_ADD.
// Chained mode feeds each result into the next term (three adders in series).
module nb_rec_step
  import nb_rec_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter int unsigned K_SUB = K_SUB_DEF,
  parameter int unsigned K_ADD = K_ADD_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             mode,
  output logic [WIDTH-1:0] a_nx,
  output logic [WIDTH-1:0] b_nx,
  output logic [WIDTH-1:0] d_nx
);

  // Constants zero-extended (or truncated) to the datapath width.
  localparam logic [WIDTH-1:0] KSUB_W = WIDTH'(K_SUB);
  localparam logic [WIDTH-1:0] KADD_W = WIDTH'(K_ADD);

  // Next values; wraparound is the natural modulo-2^WIDTH truncation.
  always_comb begin
    a_nx = b + c;
    if (mode == MODE_BLK) begin
      d_nx = a_nx - KSUB_W;
      b_nx = d_nx + KADD_W;
    end else begin
      d_nx = a - KSUB_W;
      b_nx = d + KADD_W;
    end
  end

endmodule

// File: rtl/nb_recurrence_engine.sv
// Iterates the coupled recurrence a programmable number of times.
// FSM IDLE -> RUN -> DONE; registers double as the outputs.
module nb_recurrence_engine
  import nb_rec_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter int          CNT_W = 8,
  parameter int unsigned K_SUB = K_SUB_DEF,
  parameter int unsigned K_ADD = K_ADD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] iters,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] c_out,
  output logic [WIDTH-1:0] d_out
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic [WIDTH-1:0] a, b, c, d;
  logic [WIDTH-1:0] a_nx, b_nx, d_nx;
  logic             accept, step;

  nb_rec_step #(
    .WIDTH(WIDTH),
    .K_SUB(K_SUB),
    .K_ADD(K_ADD)
  ) u_step (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .mode(mode_q),
    .a_nx(a_nx),
    .b_nx(b_nx),
    .d_nx(d_nx)
  );

  // Next state and strobes; start only matters in IDLE.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = (iters == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          step = 1'b1;
          if (cnt == CNT_W'(1)) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Working registers, counter and latched mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a      <= '0;
      b      <= '0;
      c      <= '0;
      d      <= '0;
      cnt    <= '0;
      mode_q <= MODE_NB;
    end else if (accept) begin
      a      <= a_in;
      b      <= b_in;
      c      <= c_in;
      d      <= d_in;
      cnt    <= iters;
      mode_q <= mode;
    end else if (step) begin
      a   <= a_nx;
      b   <= b_nx;
      d   <= d_nx;
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign a_out = a;
  assign b_out = b;
  assign c_out = c;
  assign d_out = d;

endmodule
